program_loader_seq: RTL
=======================

// Module: program_loader_seq
// PURPOSE
// Parametrised loader/sequencer for the integrated computer. On a start press it holds the CPU in
// reset and copies the selected program from an external program ROM into instruction memory.
// It then releases the CPU and runs it free, for a bounded number of cycles, or single-stepped.
// Successor to the fixed 3-state HW test SM; sits between the board UI and computer_integration.
// PARAMETERS
//  INSTR_W     32  instruction width
//  ADDR_W      7   instruction-memory address width (max program = 2**ADDR_W words)
//  PSEL_W      2   program-select width (up to 2**PSEL_W programs in ROM)
//  CNT_W       32  run-cycle counter width
//  RUN_CYCLES  0   free-run cycle limit; 0 = unlimited
// PORTS
//  clk            in   1        system clock
//  reset_sm       in   1        async active-low reset
//  start_n        in   1        pushbutton, active-low, asynchronous
//  step_n         in   1        pushbutton, active-low, asynchronous
//  step_mode      in   1        1 = single-step run, 0 = free run
//  program_select in   PSEL_W   program to load, sampled on start
//  prog_sel_q     out  PSEL_W   latched program select, to ROM
//  prog_rd_addr   out  ADDR_W   ROM word address
//  prog_rd_data   in   INSTR_W  ROM data, valid 1 cycle after prog_rd_addr
//  prog_len       in   ADDR_W+1 word count of prog_sel_q, combinational from ROM
//  comp_rst       out  1        0 = CPU held in reset
//  comp_en        out  1        active-low CPU enable (0 = CPU advances)
//  wr_instr_en    out  1        instruction-memory write strobe
//  wr_instr_addr  out  ADDR_W   write address
//  wr_instr       out  INSTR_W  write data
//  run_count      out  CNT_W    cycles with comp_en=0 since last load
//  state          out  3        IDLE=0 LOAD=1 VERIFY=2 RUN=3 DONE=4 ERROR=5
//  err            out  1        verify mismatch flag
// BEHAVIOUR
//  - Reset (async): comp_rst=0, comp_en=1, wr_instr_en=0, wr_instr_addr=0, wr_instr=0,
//    prog_rd_addr=0, prog_sel_q=0, run_count=0, err=0, state=IDLE. Mid-operation reset aborts
//    immediately; the next load restarts at address 0.
//  - start_n and step_n each pass through a 2-FF synchroniser. A press is one falling edge of the
//    synchronised level, so a held button is one event.
//  - IDLE: comp_rst=0. On start: latch prog_sel_q, set comp_rst=1, go to LOAD.
//  - prog_len above 2**ADDR_W is clamped to 2**ADDR_W. Let L = the clamped prog_len.
//  - LOAD: on cycle k (0..L-1) drive prog_rd_addr=k. On cycle k+1 assert wr_instr_en=1 with
//    wr_instr_addr=k and wr_instr=prog_rd_data, one write per word.
//  - LOAD exits to the next state on cycle L+1; wr_instr_en=0 from then on.
//  - LOAD with L=0 issues no write and exits on the cycle after entry.
//  - Start presses during LOAD and VERIFY are ignored.
//  - RUN, step_mode=0: comp_en=0 every cycle and run_count increments each cycle.
//    With RUN_CYCLES!=0, DONE is entered once run_count==RUN_CYCLES, leaving comp_en=1.
//  - RUN, step_mode=1: each step press drives comp_en=0 for exactly one cycle and increments
//    run_count. A step press coinciding with the limit being reached is dropped.
//  - A start press in RUN halts the CPU: comp_en=1, go to DONE.
//  - DONE: comp_en=1, comp_rst stays 1. On start: comp_rst=0 for one cycle, run_count=0,
//    re-latch program_select, go to LOAD.
//  - run_count saturates at all-ones and never wraps.
// CONFIGURATION
//  LOADER_VERIFY_EN defined:
//  - Adds ports imem_rd_addr (out, ADDR_W) and imem_rd_data (in, INSTR_W, 1-cycle latency).
//  - LOAD exits to VERIFY, which re-reads ROM and imem at address k and compares one cycle later.
//  - VERIFY lasts L+1 cycles. Any mismatch sets err=1 and goes to ERROR: comp_en=1, comp_rst=0.
//  - ERROR is left only by reset_sm; a start press in ERROR is ignored.
//  - With no mismatch VERIFY exits to RUN.
//  LOADER_VERIFY_EN undefined: LOAD exits straight to RUN; err is tied 0; VERIFY and ERROR are
//  unreachable.
// TESTING
//  1. Select 2, prog_len=21, press start -> 21 write strobes, addr 0..20, data=ROM[2][k];
//     RUN entered on cycle 22; comp_en=0 from then on.
//  2. prog_len=0 -> no wr_instr_en pulse; state reaches RUN within 2 cycles of LOAD entry.
//  3. RUN_CYCLES=100, step_mode=0 -> comp_en low exactly 100 cycles; then DONE,
//     run_count=100, comp_en=1.
//  4. step_mode=1, three step presses held 50 cycles each -> exactly three 1-cycle comp_en=0
//     pulses; run_count=3.
//  5. reset_sm low while wr_instr_addr=10 in LOAD -> every output at its reset value at once;
//     the next start writes from addr 0.
//  6. LOADER_VERIFY_EN, imem returns wrong word at addr 5 -> err=1, state=ERROR, comp_en
//     never 0; a start press is ignored.

Source files
------------

// File: rtl/program_loader_seq.sv
// program_loader_seq
//   Loader/sequencer that sits between the board UI and the integrated
//   computer. A start press holds the CPU in reset and copies the selected
//   program from the external program ROM into instruction memory. The CPU
//   is then released and runs free (optionally bounded to RUN_CYCLES) or is
//   single-stepped by the step button.
//
//   Optional feature macro: LOADER_VERIFY_EN
//     When defined, a VERIFY pass re-reads ROM and instruction memory after
//     the load and compares them word by word. A mismatch parks the loader
//     in ERROR, which only reset_sm can leave.
//
// Ports
//   clk            system clock
//   reset_sm       asynchronous active-low reset
//   start_n        start pushbutton, active-low, asynchronous
//   step_n         step pushbutton, active-low, asynchronous
//   step_mode      1 = single-step run, 0 = free run
//   program_select program to load, sampled on a start press
//   prog_sel_q     latched program select, to ROM
//   prog_rd_addr   ROM word address
//   prog_rd_data   ROM data, valid one cycle after prog_rd_addr
//   prog_len       word count of the latched program (combinational)
//   imem_rd_addr   instruction-memory read address (LOADER_VERIFY_EN only)
//   imem_rd_data   instruction-memory read data, 1-cycle latency (LOADER_VERIFY_EN only)
//   comp_rst       0 = CPU held in reset
//   comp_en        active-low CPU enable (0 = CPU advances this cycle)
//   wr_instr_en    instruction-memory write strobe
//   wr_instr_addr  instruction-memory write address
//   wr_instr       instruction-memory write data
//   run_count      cycles with comp_en=0 since the last load (saturating)
//   state          IDLE=0 LOAD=1 VERIFY=2 RUN=3 DONE=4 ERROR=5
//   err            verify mismatch flag
module program_loader_seq #(
  parameter int INSTR_W    = 32,
  parameter int ADDR_W     = 7,
  parameter int PSEL_W     = 2,
  parameter int CNT_W      = 32,
  parameter int RUN_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset_sm,
  input  logic               start_n,
  input  logic               step_n,
  input  logic               step_mode,
  input  logic [PSEL_W-1:0]  program_select,
  output logic [PSEL_W-1:0]  prog_sel_q,
  output logic [ADDR_W-1:0]  prog_rd_addr,
  input  logic [INSTR_W-1:0] prog_rd_data,
  input  logic [ADDR_W:0]    prog_len,
`ifdef LOADER_VERIFY_EN
  output logic [ADDR_W-1:0]  imem_rd_addr,
  input  logic [INSTR_W-1:0] imem_rd_data,
`endif
  output logic               comp_rst,
  output logic               comp_en,
  output logic               wr_instr_en,
  output logic [ADDR_W-1:0]  wr_instr_addr,
  output logic [INSTR_W-1:0] wr_instr,
  output logic [CNT_W-1:0]   run_count,
  output logic [2:0]         state,
  output logic               err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_VERIFY = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [ADDR_W:0]  MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(RUN_CYCLES);
  localparam bit               LIMIT_EN = (RUN_CYCLES != 0);

  logic [2:0]         r_state;
  logic [ADDR_W:0]    r_addr;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic               r_comp_rst;
  logic               r_start_s1, r_start_s2, r_start_d;
  logic               r_step_s1, r_step_s2, r_step_d;
`ifdef LOADER_VERIFY_EN
  logic               r_cmp_vld;
  logic               r_err;
`endif

  logic               w_start_evt;
  logic               w_step_evt;
  logic [ADDR_W:0]    w_len;
  logic               w_at_limit;
  logic               w_hit;
  logic               w_adv;

  // Button synchronisers; idle level is high so reset never fakes a press.
  always_ff @(posedge clk or negedge reset_sm) begin
    if (!reset_sm) begin
      r_start_s1 <= 1'b1;
      r_start_s2 <= 1'b1;
      r_start_d  <= 1'b1;
      r_step_s1  <= 1'b1;
      r_step_s2  <= 1'b1;
      r_step_d   <= 1'b1;
    end else begin
      r_start_s1 <= start_n;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
      r_step_s1  <= step_n;
      r_step_s2  <= r_step_s1;
      r_step_d   <= r_step_s2;
    end
  end

  // A press is the falling edge of the synchronised level.
  assign w_start_evt = r_start_d & ~r_start_s2;
  assign w_step_evt  = r_step_d & ~r_step_s2;

  assign w_len      = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign w_at_limit = LIMIT_EN && (run_count >= LIMIT);
  assign w_hit      = LIMIT_EN && ((run_count + 1'b1) == LIMIT);

  // CPU advances this cycle; a start press or an exhausted budget wins over a step.
  assign w_adv = (r_state == S_RUN) && !w_start_evt && !w_at_limit &&
                 (!step_mode || w_step_evt);

  always_ff @(posedge clk or negedge reset_sm) begin
    if (!reset_sm) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_comp_rst <= 1'b0;
      prog_sel_q <= '0;
      run_count  <= '0;
`ifdef LOADER_VERIFY_EN
      r_cmp_vld  <= 1'b0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
`ifdef LOADER_VERIFY_EN
      r_cmp_vld <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start_evt) begin
            prog_sel_q <= program_select;
            r_comp_rst <= 1'b1;
            r_addr     <= '0;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_comp_rst <= 1'b1;
          // Address k goes out now; its ROM word is written next cycle.
          if (r_addr < w_len) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr[ADDR_W-1:0];
            r_addr    <= r_addr + 1'b1;
          end else begin
            r_addr <= '0;
`ifdef LOADER_VERIFY_EN
            r_state <= S_VERIFY;
`else
            r_state <= S_RUN;
`endif
          end
        end
`ifdef LOADER_VERIFY_EN
        S_VERIFY: begin
          // r_cmp_vld marks a cycle whose read data belongs to the previous address.
          if (r_cmp_vld && (prog_rd_data != imem_rd_data)) begin
            r_err      <= 1'b1;
            r_comp_rst <= 1'b0;
            r_addr     <= '0;
            r_state    <= S_ERROR;
          end else if (r_addr < w_len) begin
            r_cmp_vld <= 1'b1;
            r_addr    <= r_addr + 1'b1;
          end else begin
            r_addr  <= '0;
            r_state <= S_RUN;
          end
        end
        S_ERROR: begin
          r_comp_rst <= 1'b0;
        end
`endif
        S_RUN: begin
          if (w_start_evt || w_at_limit) begin
            r_state <= S_DONE;
          end else if (w_adv) begin
            if (!(&run_count)) run_count <= run_count + 1'b1;
            if (w_hit) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_start_evt) begin
            // One cycle of CPU reset before the reload begins.
            r_comp_rst <= 1'b0;
            run_count  <= '0;
            prog_sel_q <= program_select;
            r_addr     <= '0;
            r_state    <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign prog_rd_addr  = r_addr[ADDR_W-1:0];
  assign comp_rst      = r_comp_rst;
  assign comp_en       = ~w_adv;
  assign wr_instr_en   = r_wr_en;
  assign wr_instr_addr = r_wr_addr;
  assign wr_instr      = r_wr_en ? prog_rd_data : '0;
  assign state         = r_state;
`ifdef LOADER_VERIFY_EN
  assign imem_rd_addr  = r_addr[ADDR_W-1:0];
  assign err           = r_err;
`else
  assign err           = 1'b0;
`endif

endmodule
